// File: rtl/onewire_slave.sv
// 1-wire slave: bus reset/presence, command byte, fixed-length READ/WRITE payload.
// Define ONEWIRE_CRC8_EN to append (TX) and check (RX) a Dallas CRC-8 byte.
module onewire_slave #(
    parameter int         CLK_PER_US = 100,
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] CMD_READ   = 8'hBE,
    parameter logic [7:0] CMD_WRITE  = 8'h4E
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dq_in,
    output logic                    dq_oe,
    input  logic [8*DATA_BYTES-1:0] tx_data,
    output logic [8*DATA_BYTES-1:0] rx_data,
    output logic                    rx_valid,
    output logic                    cmd_err,
    output logic                    busy
);
`ifdef ONEWIRE_CRC8_EN
    localparam int CRC_BYTES = 1;
`else
    localparam int CRC_BYTES = 0;
`endif
    localparam int PW      = 8 * DATA_BYTES;
    localparam int NBITS   = 8 * (DATA_BYTES + CRC_BYTES);
    localparam int RST_CYC = 480 * CLK_PER_US;
    localparam int LW      = $clog2(RST_CYC + 1);
    localparam int TW      = $clog2(120 * CLK_PER_US);
    localparam int BW      = $clog2(8 * (DATA_BYTES + 1) + 1);

    localparam logic [LW-1:0] RST_M1   = LW'(RST_CYC - 1);
    localparam logic [LW-1:0] RST_MAX  = LW'(RST_CYC);
    localparam logic [TW-1:0] T30_M1   = TW'(30 * CLK_PER_US - 1);
    localparam logic [TW-1:0] T120_M1  = TW'(120 * CLK_PER_US - 1);
    localparam logic [BW-1:0] CMD_LAST = BW'(7);
    localparam logic [BW-1:0] DAT_LAST = BW'(NBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRES_WAIT, S_PRES_DRIVE, S_CMD, S_TX, S_RX
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_dq_prev;
    logic [LW-1:0]     r_low_cnt;
    logic              r_rst_armed;
    logic [TW-1:0]     r_tmr;
    logic              r_slot_act;
    logic [BW-1:0]     r_bit_cnt;
    logic [NBITS-1:0]  r_shift;
    logic [NBITS-1:0]  r_tx_shift;
    logic              r_rx_done;
    logic [PW-1:0]     r_rx_data;
    logic              r_rx_valid;
    logic              r_cmd_err;

    logic              w_fall;
    logic              w_rise;
    logic              w_bus_rst;
    logic              w_tmr_zero;
    logic              w_slot_end;
    logic [NBITS-1:0]  w_shift_nxt;
    logic [7:0]        w_cmd;
    logic              w_crc_ok;
    logic [NBITS-1:0]  w_tx_load;

    assign w_fall      = r_dq_prev & ~r_sync2;
    assign w_rise      = ~r_dq_prev & r_sync2;
    assign w_bus_rst   = ~r_sync2 && (r_low_cnt == RST_M1);
    assign w_tmr_zero  = (r_tmr == '0);
    assign w_slot_end  = r_slot_act & w_tmr_zero;
    assign w_shift_nxt = {r_sync2, r_shift[NBITS-1:1]};
    assign w_cmd       = w_shift_nxt[NBITS-1 -: 8];

`ifdef ONEWIRE_CRC8_EN
    function automatic logic [7:0] crc8(input logic [PW-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < PW; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign w_crc_ok  = (crc8(r_shift[PW-1:0]) == r_shift[NBITS-1 -: 8]);
    assign w_tx_load = {crc8(tx_data), tx_data};
`else
    assign w_crc_ok  = 1'b1;
    assign w_tx_load = tx_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (w_bus_rst) begin
            w_nxt = S_IDLE;
        end else if (w_rise && r_rst_armed) begin
            w_nxt = S_PRES_WAIT;
        end else begin
            unique case (r_state)
                S_PRES_WAIT:  if (w_tmr_zero) w_nxt = S_PRES_DRIVE;
                S_PRES_DRIVE: if (w_tmr_zero) w_nxt = S_CMD;
                S_CMD: begin
                    if (w_slot_end && r_bit_cnt == CMD_LAST) begin
                        if (w_cmd == CMD_READ)       w_nxt = S_TX;
                        else if (w_cmd == CMD_WRITE) w_nxt = S_RX;
                        else                         w_nxt = S_IDLE;
                    end
                end
                S_TX, S_RX: begin
                    if (w_slot_end && r_bit_cnt == DAT_LAST) w_nxt = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dq_oe = 1'b0;
        busy  = 1'b1;
        unique case (r_state)
            S_IDLE:       busy  = 1'b0;
            S_PRES_DRIVE: dq_oe = 1'b1;
            S_TX:         dq_oe = r_slot_act & ~r_tx_shift[0];
            default: ;
        endcase
    end

    // Sync, low-time watchdog and slot datapath; r_tmr is shared by presence and slots
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_dq_prev   <= 1'b1;
            r_low_cnt   <= '0;
            r_rst_armed <= 1'b0;
            r_tmr       <= '0;
            r_slot_act  <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx_shift  <= '0;
            r_rx_done   <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_sync1    <= dq_in;
            r_sync2    <= r_sync1;
            r_dq_prev  <= r_sync2;
            r_rx_valid <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_rx_done  <= 1'b0;

            if (r_rx_done && w_crc_ok) begin
                r_rx_data  <= r_shift[PW-1:0];
                r_rx_valid <= 1'b1;
            end

            if (r_sync2)                   r_low_cnt <= '0;
            else if (r_low_cnt != RST_MAX) r_low_cnt <= r_low_cnt + 1'b1;

            if (w_bus_rst)   r_rst_armed <= 1'b1;
            else if (w_rise) r_rst_armed <= 1'b0;

            if (w_bus_rst) begin
                r_slot_act <= 1'b0;
            end else if (w_rise && r_rst_armed) begin
                r_slot_act <= 1'b0;
                r_tmr      <= T30_M1;
            end else begin
                unique case (r_state)
                    S_PRES_WAIT: r_tmr <= w_tmr_zero ? T120_M1 : r_tmr - 1'b1;
                    S_PRES_DRIVE: begin
                        if (!w_tmr_zero) r_tmr <= r_tmr - 1'b1;
                        r_bit_cnt  <= '0;
                        r_slot_act <= 1'b0;
                    end
                    S_CMD, S_TX, S_RX: begin
                        if (r_slot_act) begin
                            if (!w_tmr_zero) begin
                                r_tmr <= r_tmr - 1'b1;
                            end else begin
                                r_slot_act <= 1'b0;
                                r_bit_cnt  <= r_bit_cnt + 1'b1;
                                r_shift    <= w_shift_nxt;
                                r_tx_shift <= r_tx_shift >> 1;
                                if (r_state == S_CMD && r_bit_cnt == CMD_LAST) begin
                                    r_bit_cnt <= '0;
                                    if (w_cmd == CMD_READ)       r_tx_shift <= w_tx_load;
                                    else if (w_cmd != CMD_WRITE) r_cmd_err  <= 1'b1;
                                end
                                if (r_state == S_RX && r_bit_cnt == DAT_LAST)
                                    r_rx_done <= 1'b1;
                            end
                        end else if (w_fall) begin
                            r_slot_act <= 1'b1;
                            r_tmr      <= T30_M1;
                        end
                    end
                    default: r_slot_act <= 1'b0;
                endcase
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign cmd_err  = r_cmd_err;

endmodule
